// File: rtl/cmm_result_serializer.sv
// Buffers one complex_matrix_mul result bundle and replays it as one complex
// element per beat, tagged with its index and a last marker.
module cmm_result_serializer #(
  parameter int unsigned SIZE  = 16,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned IDX_W = $clog2(SIZE)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [2*SIZE-1:0][WIDTH-1:0]     result_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [WIDTH-1:0]                 out_re_o,
  output logic [WIDTH-1:0]                 out_im_o,
  output logic [IDX_W-1:0]                 out_idx_o,
  output logic                             out_last_o,
  output logic                             busy_o
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  state_e                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [2*SIZE-1:0][WIDTH-1:0] bundle_q;
  logic                         capture;
  logic                         is_last;
  logic [IDX_W:0]               re_sel;
  logic [IDX_W:0]               im_sel;

  assign is_last = (idx_q == LAST_IDX);
  assign re_sel  = {idx_q, 1'b0};
  assign im_sel  = {idx_q, 1'b1};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    capture     = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        out_valid_o = 1'b1;
        // Ready to refill only as the final beat leaves: zero-bubble chaining.
        in_ready_o  = is_last && out_ready_i;
        if (out_ready_i) begin
          if (!is_last) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            idx_d = '0;
            if (in_valid_i) begin
              capture = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    // Reset and flush override any concurrent handshake.
    if (!rst_ni || flush_i) begin
      in_ready_o = 1'b0;
      capture    = 1'b0;
      state_d    = IDLE;
      idx_d      = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      bundle_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (capture) begin
        bundle_q <= result_i;
      end
    end
  end

  assign busy_o     = (state_q == STREAM);
  assign out_last_o = (state_q == STREAM) && is_last;
  assign out_idx_o  = idx_q;
  assign out_re_o   = (state_q == STREAM) ? bundle_q[re_sel] : '0;
  assign out_im_o   = (state_q == STREAM) ? bundle_q[im_sel] : '0;

endmodule
